spi_flash_read_sequencer: RTL

- Sequences serial reads from the configuration SPI flash on the FPGA platform.
- Issues the READ command (0x03) plus a 24-bit address, then streams the returned bytes to the fabric through a valid/ready interface.
- spi_flash_sclk is routed to the STARTUPE2 USRCCLKO pin at FPGA top level. CSN, MOSI and MISO go to ordinary flash pins.
- SPI mode 0 only.

---
 rtl/spi_flash_read_sequencer.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/spi_flash_read_sequencer.sv
// SPI mode-0 flash read sequencer: issues READ (0x03) + 24-bit address, then
// streams the returned bytes out through a one-deep valid/ready holding register.
module spi_flash_read_sequencer #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned CS_IDLE  = 4
) (
    input  logic        clk,
    input  logic        rstnn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    input  logic [15:0] req_len,
    output logic [7:0]  rdata,
    output logic        rdata_valid,
    input  logic        rdata_ready,
    output logic        done,
    output logic        busy,
    output logic        spi_flash_sclk,
    output logic        spi_flash_csn,
    output logic        spi_flash_mosi,
    input  logic        spi_flash_miso
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MAX_CNT = max2(max2(CLK_DIV, CS_SETUP), max2(CS_HOLD, CS_IDLE));
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(CS_IDLE - 1);
    localparam logic [7:0]       READ_CMD   = 8'h03;

    typedef enum logic [2:0] {
        IDLE, SETUP, SHIFT_TX, SHIFT_RX, STALL, HOLD, GAP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             phase_hi;
    logic [4:0]       bit_idx;
    logic [31:0]      tx_sr;
    logic [7:0]       rx_sr;
    logic [15:0]      bytes_left;
    logic             hold_busy;

    // Holding register still owns an unconsumed byte this cycle.
    assign hold_busy = rdata_valid && !rdata_ready;

    always_ff @(posedge clk) begin
        if (!rstnn) begin
            state          <= IDLE;
            cnt            <= '0;
            phase_hi       <= 1'b0;
            bit_idx        <= '0;
            tx_sr          <= '0;
            rx_sr          <= '0;
            bytes_left     <= '0;
            req_ready      <= 1'b0;
            rdata          <= '0;
            rdata_valid    <= 1'b0;
            done           <= 1'b0;
            busy           <= 1'b0;
            spi_flash_sclk <= 1'b0;
            spi_flash_csn  <= 1'b1;
            spi_flash_mosi <= 1'b0;
        end else begin
            done <= 1'b0;
            if (rdata_valid && rdata_ready) begin
                rdata_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (req_valid && req_ready) begin
                        if (req_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            state          <= SETUP;
                            req_ready      <= 1'b0;
                            busy           <= 1'b1;
                            spi_flash_csn  <= 1'b0;
                            spi_flash_mosi <= READ_CMD[7];
                            tx_sr          <= {READ_CMD, req_addr};
                            bytes_left     <= req_len;
                            cnt            <= '0;
                        end
                    end
                end

                // The setup wait doubles as the low phase of the first TX bit,
                // so csn-low to first sclk rise is exactly CS_SETUP cycles.
                SETUP: begin
                    if (cnt == SETUP_LAST) begin
                        spi_flash_sclk <= 1'b1;
                        phase_hi       <= 1'b1;
                        cnt            <= '0;
                        bit_idx        <= '0;
                        state          <= SHIFT_TX;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                SHIFT_TX, SHIFT_RX: begin
                    if (cnt != DIV_LAST) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt            <= '0;
                        phase_hi       <= !phase_hi;
                        spi_flash_sclk <= !phase_hi;
                        if (!phase_hi) begin
                            if (state == SHIFT_RX) begin
                                rx_sr <= {rx_sr[6:0], spi_flash_miso};
                                if (bit_idx == 5'd7) begin
                                    rdata       <= {rx_sr[6:0], spi_flash_miso};
                                    rdata_valid <= 1'b1;
                                    bytes_left  <= bytes_left - 1'b1;
                                end
                            end
                        end else if (state == SHIFT_TX && bit_idx != 5'd31) begin
                            tx_sr          <= {tx_sr[30:0], 1'b0};
                            spi_flash_mosi <= tx_sr[30];
                            bit_idx        <= bit_idx + 1'b1;
                        end else if (state == SHIFT_RX && bit_idx != 5'd7) begin
                            bit_idx <= bit_idx + 1'b1;
                        end else begin
                            // Byte boundary: end of TX word or of an RX byte.
                            spi_flash_mosi <= 1'b0;
                            bit_idx        <= '0;
                            if (state == SHIFT_RX && bytes_left == '0) begin
                                state <= HOLD;
                            end else if (hold_busy) begin
                                state <= STALL;
                            end else begin
                                state <= SHIFT_RX;
                            end
                        end
                    end
                end

                STALL: begin
                    if (!hold_busy) begin
                        state    <= SHIFT_RX;
                        cnt      <= '0;
                        phase_hi <= 1'b0;
                    end
                end

                HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        spi_flash_csn <= 1'b1;
                        cnt           <= '0;
                        state         <= GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                GAP: begin
                    if (cnt == IDLE_LAST) begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        cnt       <= '0;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
